// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter
// -----------------------------------------------------------------------------
// Shares one bit-serial 2:1-mux gate cell between two requesters. An idle
// controller picks a winner round-robin, latches its opcode and operands,
// and then walks the mux cell over the operand bits LSB first, one bit per
// cycle. The assembled result is returned with a one-cycle tagged strobe.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req0/req1  request levels, sampled only while idle
//   op0/op1    3-bit opcodes (0 AND,1 OR,2 NOT,3 XOR,4 XNOR,5 NAND,6 NOR,7 see below)
//   a0/b0,a1/b1  W-bit operands
//   gnt        one-hot registered grant pulse
//   busy       high whenever the controller is not idle
//   rsp_valid  one-cycle result strobe
//   rsp_id     requester index of the result
//   rsp_data   W-bit result, held until the next strobe
//   err        illegal-opcode pulse (only when GATE_ARB_ERR_EN is defined)
//
// Build option GATE_ARB_ERR_EN: opcode 7 becomes illegal; it is granted but
// skips the bit-serial pass and answers with err and zero data in cycle 2.
// Without it, opcode 7 passes operand a through with normal latency.
// -----------------------------------------------------------------------------
module gate_unit_arbiter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic [2:0]   op0,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic         req1,
   input  logic [2:0]   op1,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic [1:0]   gnt,
   output logic         busy,
   output logic         rsp_valid,
   output logic         rsp_id,
   output logic [W-1:0] rsp_data
`ifdef GATE_ARB_ERR_EN
   ,
   output logic         err
`endif
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rr_q, rr_d;
   logic          id_q, id_d;
   logic [2:0]    op_q, op_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  res_q, res_d;
   logic [1:0]    gnt_q, gnt_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_id_q, rsp_id_d;
   logic [W-1:0]  rsp_data_q, rsp_data_d;
`ifdef GATE_ARB_ERR_EN
   logic          err_q, err_d;
   logic          pend_q, pend_d;
`endif

   logic          win;
   logic [2:0]    win_op;
   logic          cell_sel;
   logic          cell_in0;
   logic          cell_in1;
   logic          cell_out;

   // The shared gate cell: operand a drives the mux select and the per-opcode
   // constants or b/~b drive the data legs. NOT is the one case where b
   // itself is the select, since a is ignored.
   always_comb begin
      cell_sel = a_q[cnt_q];
      cell_in0 = 1'b0;
      cell_in1 = 1'b1;
      case (op_q)
         3'd0: begin cell_in0 = 1'b0;          cell_in1 = b_q[cnt_q];  end
         3'd1: begin cell_in0 = b_q[cnt_q];    cell_in1 = 1'b1;        end
         3'd2: begin cell_sel = b_q[cnt_q];    cell_in0 = 1'b1; cell_in1 = 1'b0; end
         3'd3: begin cell_in0 = b_q[cnt_q];    cell_in1 = ~b_q[cnt_q]; end
         3'd4: begin cell_in0 = ~b_q[cnt_q];   cell_in1 = b_q[cnt_q];  end
         3'd5: begin cell_in0 = 1'b1;          cell_in1 = ~b_q[cnt_q]; end
         3'd6: begin cell_in0 = ~b_q[cnt_q];   cell_in1 = 1'b0;        end
         default: begin cell_in0 = 1'b0;       cell_in1 = 1'b1;        end
      endcase
      cell_out = cell_sel ? cell_in1 : cell_in0;
   end

   // Winner selection: with both requesting the round-robin pointer decides,
   // otherwise whichever single requester is high wins.
   always_comb begin
      win    = (req0 && req1) ? rr_q : req1;
      win_op = win ? op1 : op0;
   end

   // Controller next-state logic. Pulse outputs default low every cycle;
   // the response fields hold their value between strobes.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_d        = rr_q;
      id_d        = id_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      gnt_d       = 2'b00;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
`ifdef GATE_ARB_ERR_EN
      err_d       = 1'b0;
      pend_d      = pend_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               id_d    = win;
               op_d    = win_op;
               a_d     = win ? a1 : a0;
               b_d     = win ? b1 : b0;
               gnt_d   = win ? 2'b10 : 2'b01;
               rr_d    = ~win;
               cnt_d   = '0;
               res_d   = '0;
               state_d = RUN;
`ifdef GATE_ARB_ERR_EN
               // An illegal opcode is still granted but never runs the cell.
               if (win_op == 3'd7) begin
                  state_d = DONE;
                  pend_d  = 1'b1;
               end
`endif
            end
         end
         RUN: begin
            res_d[cnt_q] = cell_out;
            if (cnt_q == LAST) begin
               state_d     = DONE;
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_data_d  = res_d;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
`ifdef GATE_ARB_ERR_EN
            // The illegal-opcode path spends one DONE cycle raising the
            // strobe so that err and rsp_valid appear in cycle 2.
            if (pend_q) begin
               pend_d      = 1'b0;
               rsp_valid_d = 1'b1;
               err_d       = 1'b1;
               rsp_id_d    = id_q;
               rsp_data_d  = '0;
            end else begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset; an in-flight operation is
   // simply dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rr_q        <= 1'b0;
         id_q        <= 1'b0;
         op_q        <= 3'd0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         gnt_q       <= 2'b00;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
`ifdef GATE_ARB_ERR_EN
         err_q       <= 1'b0;
         pend_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_q        <= rr_d;
         id_q        <= id_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
`ifdef GATE_ARB_ERR_EN
         err_q       <= err_d;
         pend_q      <= pend_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign busy      = (state_q != IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
`ifdef GATE_ARB_ERR_EN
   assign err       = err_q;
`endif

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// tb_gate_unit_arbiter
// -----------------------------------------------------------------------------
// Self-checking bench for gate_unit_arbiter (W = 8). Expected responses are
// pushed to a scoreboard queue when a request is driven and popped by a
// monitor whenever the design raises rsp_valid. Grant timing, latency,
// round-robin order and reset abort are checked from the main sequence.
// -----------------------------------------------------------------------------
module tb_gate_unit_arbiter;

   localparam int W = 8;

   typedef struct packed {
      logic         id;
      logic [W-1:0] data;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         req0, req1;
   logic [2:0]   op0, op1;
   logic [W-1:0] a0, b0, a1, b1;
   logic [1:0]   gnt;
   logic         busy;
   logic         rsp_valid;
   logic         rsp_id;
   logic [W-1:0] rsp_data;
`ifdef GATE_ARB_ERR_EN
   logic         err;
`endif

   exp_t expQ[$];
   int   checks;
   int   errors;
   int   cyc;

   gate_unit_arbiter #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .op0       (op0),
      .a0        (a0),
      .b0        (b0),
      .req1      (req1),
      .op1       (op1),
      .a1        (a1),
      .b1        (b1),
      .gnt       (gnt),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
`ifdef GATE_ARB_ERR_EN
      .rsp_data  (rsp_data),
      .err       (err)
`else
      .rsp_data  (rsp_data)
`endif
   );

   // Free-running clock and cycle stamp used for grant spacing.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference behaviour written as plain boolean operators, independent of
   // the mux-cell formulation inside the design.
   function automatic logic [W-1:0] refOp(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      case (op)
         3'd0: refOp = a & b;
         3'd1: refOp = a | b;
         3'd2: refOp = ~b;
         3'd3: refOp = a ^ b;
         3'd4: refOp = ~(a ^ b);
         3'd5: refOp = ~(a & b);
         3'd6: refOp = ~(a | b);
`ifdef GATE_ARB_ERR_EN
         default: refOp = '0;
`else
         default: refOp = a;
`endif
      endcase
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every result strobe must match the oldest entry.
   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
            checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
         end
      end
   end

   // Drive one request (mask selects which requesters assert, both with the
   // same operands), check the grant, the result latency and the return to idle.
   task automatic applyStimulus(input logic [1:0] mask, input logic expWin, input logic [2:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      int expLat;
      exp_t e;
      e.id   = expWin;
      e.data = refOp(op, a, b);
      expLat = W + 1;
`ifdef GATE_ARB_ERR_EN
      if (op == 3'd7) expLat = 2;
`endif
      expQ.push_back(e);
      req0 = mask[0]; op0 = op; a0 = a; b0 = b;
      req1 = mask[1]; op1 = op; a1 = a; b1 = b;
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
      checkOutput("gnt", 32'(gnt), expWin ? 32'd2 : 32'd1);
      checkOutput("busy_run", 32'(busy), 32'd1);
      lat = W + 11;
      for (int k = 2; k <= W + 10; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = k;
            break;
         end
      end
      checkOutput("latency", 32'(lat), 32'(expLat));
`ifdef GATE_ARB_ERR_EN
      checkOutput("err", 32'(err), (op == 3'd7) ? 32'd1 : 32'd0);
`endif
      @(negedge clk);
      checkOutput("busy_after", 32'(busy), 32'd0);
   endtask

   logic [W-1:0] opTable [7];
   logic [1:0]   gv [4];
   int           gc [4];
   int           gcount;
   int           seen;

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      rst  = 1'b1;
      req0 = 1'b0; op0 = 3'd0; a0 = '0; b0 = '0;
      req1 = 1'b0; op1 = 3'd0; a1 = '0; b1 = '0;
      opTable = '{8'h88, 8'hEE, 8'h55, 8'h66, 8'h99, 8'h77, 8'h11};

      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
      rst = 1'b0;

      // Quiet idle period with no requests.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("idle_quiet", 32'({gnt, busy, rsp_valid}), 32'd0);
      end

      // Single XOR operation.
      $display("[TB] single XOR");
      applyStimulus(2'b01, 1'b0, 3'd3, 8'hF0, 8'hAA);
      checkOutput("xor_value", 32'(rsp_data), 32'h5A);

      // Every legal opcode on a fixed operand pair.
      $display("[TB] opcode sweep");
      for (int op = 0; op < 7; op++) begin
         applyStimulus(2'b01, 1'b0, 3'(op), 8'hCC, 8'hAA);
         checkOutput("opcode_value", 32'(rsp_data), 32'(opTable[op]));
      end

      // Both requesters held high: grants alternate from a fresh pointer.
      $display("[TB] round robin");
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      req0 = 1'b1; op0 = 3'd3; a0 = 8'hF0; b0 = 8'hAA;
      req1 = 1'b1; op1 = 3'd0; a1 = 8'hCC; b1 = 8'hAA;
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         e.id   = i[0];
         e.data = i[0] ? 8'h88 : 8'h5A;
         expQ.push_back(e);
      end
      gcount = 0;
      for (int k = 0; k < 60 && gcount < 4; k++) begin
         @(negedge clk);
         if (gnt != 2'b00) begin
            gv[gcount] = gnt;
            gc[gcount] = cyc;
            gcount++;
            if (gcount == 4) begin
               req0 = 1'b0;
               req1 = 1'b0;
            end
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      checkOutput("rr_grant_count", 32'(gcount), 32'd4);
      for (int i = 0; i < gcount; i++) begin
         checkOutput("rr_grant", 32'(gv[i]), i[0] ? 32'd2 : 32'd1);
         if (i > 0) checkOutput("rr_spacing", 32'(gc[i] - gc[i-1]), 32'(W + 2));
      end
      repeat (W + 4) @(negedge clk);
      checkOutput("rr_drained", 32'(expQ.size()), 32'd0);

      // Reset in RUN cycle 4 aborts the operation and restores the pointer.
      $display("[TB] reset abort");
      req0 = 1'b1; op0 = 3'd0; a0 = 8'hFF; b0 = 8'hFF;
      @(negedge clk);
      req0 = 1'b0;
      checkOutput("abort_gnt", 32'(gnt), 32'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_gnt_low", 32'(gnt), 32'd0);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < W + 4; k++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      checkOutput("abort_no_rsp", 32'(seen), 32'd0);
      applyStimulus(2'b11, 1'b0, 3'd1, 8'h0F, 8'h30);
      applyStimulus(2'b10, 1'b1, 3'd5, 8'h5A, 8'h3C);

      // Reserved opcode 7.
      $display("[TB] opcode 7");
      applyStimulus(2'b01, 1'b0, 3'd7, 8'h3C, 8'h81);
`ifdef GATE_ARB_ERR_EN
      checkOutput("op7_value", 32'(rsp_data), 32'h00);
`else
      checkOutput("op7_value", 32'(rsp_data), 32'h3C);
`endif

      repeat (3) @(negedge clk);
      checkOutput("final_drained", 32'(expQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
